// File: rtl/delay_pipe_credit_fifo_if.sv
// Handshake bundle for the credit-managed receive buffer: issue credit, pipe push and consumer pop.
// The slave modport is the buffer; the master modport is the issuer/pipe/consumer side.
interface delay_pipe_credit_fifo_if #(
    parameter int W = 32,
    parameter int D = 8
);
    logic                       iss_vld;
    logic                       iss_rdy;
    logic [W-1:0]               pipe_dat;
    logic                       pipe_vld;
    logic [W-1:0]               out_dat;
    logic                       out_vld;
    logic                       out_rdy;
    logic [$clog2(D+1)-1:0]     credits_r;
    logic                       err_r;

    modport master (
        output iss_vld, pipe_dat, pipe_vld, out_rdy,
        input  iss_rdy, out_dat, out_vld, credits_r, err_r
    );

    modport slave (
        input  iss_vld, pipe_dat, pipe_vld, out_rdy,
        output iss_rdy, out_dat, out_vld, credits_r, err_r
    );
endinterface

// File: rtl/delay_pipe_credit_fifo.sv
// Receive FIFO behind a no-backpressure delay pipe; credits gate issue into the pipe
// and return one at a time as the consumer pops words.
module delay_pipe_credit_fifo #(
    parameter int W = 32,
    parameter int D = 8
) (
    input logic                     clk,
    input logic                     rst,
    delay_pipe_credit_fifo_if.slave bus
);
    localparam int            CW    = $clog2(D + 1);
    localparam int            PW    = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] D_CNT = CW'(D);
    localparam logic [PW-1:0] LAST  = PW'(D - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic          err_q, err_d;
    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];

    logic iss;
    logic pop;
    logic full;
    logic push_ok;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        iss     = bus.iss_vld & (cnt_q != '0);
        pop     = (occ_q != '0) & bus.out_rdy;
        full    = (occ_q == D_CNT);
        // At full a simultaneous pop frees the slot the write lands in.
        push_ok = bus.pipe_vld & (~full | pop);

        cnt_d = cnt_q;
        if (iss && !pop) begin
            cnt_d = cnt_q - 1'b1;
        end else if (pop && !iss) begin
            cnt_d = cnt_q + 1'b1;
        end

        occ_d = occ_q;
        if (push_ok && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push_ok) begin
            occ_d = occ_q - 1'b1;
        end

        wr_d  = push_ok ? next_ptr(wr_q) : wr_q;
        rd_d  = pop ? next_ptr(rd_q) : rd_q;
        err_d = err_q | (bus.iss_vld & (cnt_q == '0)) | (bus.pipe_vld & full & ~pop);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q] = bus.pipe_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= D_CNT;
            occ_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            occ_q <= occ_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            err_q <= err_d;
        end
    end

    // Storage needs no reset; out_dat is only meaningful while out_vld is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.iss_rdy   = (cnt_q != '0);
    assign bus.out_vld   = (occ_q != '0);
    assign bus.out_dat   = mem_q[rd_q];
    assign bus.credits_r = cnt_q;
    assign bus.err_r     = err_q;
endmodule

// File: tb/tb_delay_pipe_credit_fifo.sv
// Scoreboard bench: two buffers (D=4 and D=3) each behind a 2-stage pipe model;
// expected words are queued at issue time and checked by a negedge monitor.
module tb_delay_pipe_credit_fifo;
    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        iss_vld [2];
    logic [31:0] iss_dat [2];
    logic        frc_vld [2];
    logic [31:0] frc_dat [2];
    logic        out_rdy [2];
    logic        s1_vld  [2];
    logic        s2_vld  [2];
    logic [31:0] s1_dat  [2];
    logic [31:0] s2_dat  [2];
    logic        rdy_w   [2];

    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    delay_pipe_credit_fifo_if #(.W(32), .D(4)) bus_a ();
    delay_pipe_credit_fifo_if #(.W(32), .D(3)) bus_b ();

    delay_pipe_credit_fifo #(.W(32), .D(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    delay_pipe_credit_fifo #(.W(32), .D(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rdy_w[0] = bus_a.iss_rdy;
    assign rdy_w[1] = bus_b.iss_rdy;

    // Two-stage pipe per buffer; only accepted issues launch, and it is held in reset with the buffers.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                s1_vld[i] <= 1'b0;
                s2_vld[i] <= 1'b0;
            end else begin
                s1_vld[i] <= iss_vld[i] & rdy_w[i];
                s1_dat[i] <= iss_dat[i];
                s2_vld[i] <= s1_vld[i];
                s2_dat[i] <= s1_dat[i];
            end
        end
    end

    assign bus_a.iss_vld  = iss_vld[0];
    assign bus_a.pipe_vld = s2_vld[0] | frc_vld[0];
    assign bus_a.pipe_dat = frc_vld[0] ? frc_dat[0] : s2_dat[0];
    assign bus_a.out_rdy  = out_rdy[0];
    assign bus_b.iss_vld  = iss_vld[1];
    assign bus_b.pipe_vld = s2_vld[1] | frc_vld[1];
    assign bus_b.pipe_dat = frc_vld[1] ? frc_dat[1] : s2_dat[1];
    assign bus_b.out_rdy  = out_rdy[1];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_pop(input int sel, input logic [31:0] act);
        exp_t e;
        int   sz;
        sz = (sel == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output dut%0d: got %08h expected no word", sel, act);
        end else begin
            if (sel == 0) e = exp_q0.pop_front();
            else          e = exp_q1.pop_front();
            checkOutput((sel == 0) ? "out_dat_a" : "out_dat_b", act, e.dat);
            if (e.due >= 0) checkOutput((sel == 0) ? "latency_a" : "latency_b", cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.out_vld && out_rdy[0]) check_pop(0, bus_a.out_dat);
            if (bus_b.out_vld && out_rdy[1]) check_pop(1, bus_b.out_dat);
        end
    end

    function automatic longint get_credits(input int sel);
        return (sel == 0) ? longint'(bus_a.credits_r) : longint'(bus_b.credits_r);
    endfunction

    function automatic longint get_rdy(input int sel);
        return (sel == 0) ? longint'(bus_a.iss_rdy) : longint'(bus_b.iss_rdy);
    endfunction

    function automatic longint get_vld(input int sel);
        return (sel == 0) ? longint'(bus_a.out_vld) : longint'(bus_b.out_vld);
    endfunction

    function automatic longint get_err(input int sel);
        return (sel == 0) ? longint'(bus_a.err_r) : longint'(bus_b.err_r);
    endfunction

    function automatic int q_size(input int sel);
        return (sel == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic expect_word(input int sel, input logic [31:0] dat, input int due);
        exp_t e;
        e.dat = dat;
        e.due = due;
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    // One cycle: step past the edge, then drive this cycle's inputs for one buffer.
    task automatic applyStimulus(input int sel, input bit iv, input bit fv,
                                 input logic [31:0] d, input bit ordy);
        @(posedge clk);
        #1;
        iss_vld[sel] = iv;
        iss_dat[sel] = d;
        frc_vld[sel] = fv;
        frc_dat[sel] = d;
        out_rdy[sel] = ordy;
    endtask

    task automatic drain(input int sel);
        for (int i = 0; i < 30 && q_size(sel) != 0; i++) applyStimulus(sel, 0, 0, 32'h0, 1);
        checkOutput("drain_left", q_size(sel), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iss_vld[i] = 1'b0;
            iss_dat[i] = '0;
            frc_vld[i] = 1'b0;
            frc_dat[i] = '0;
            out_rdy[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        exp_q0.delete();
        exp_q1.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        do_reset();
        checkOutput("rst_credits_a", get_credits(0), 4);
        checkOutput("rst_rdy_a", get_rdy(0), 1);
        checkOutput("rst_vld_a", get_vld(0), 0);
        checkOutput("rst_err_a", get_err(0), 0);
        checkOutput("rst_credits_b", get_credits(1), 3);

        // Stall fill on the D=4 buffer, then release the consumer.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 32'hA0 + k, 0);
            checkOutput("fill_credits", get_credits(0), 4 - k);
            expect_word(0, 32'hA0 + k, -1);
        end
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fill_rdy", get_rdy(0), 0);
        checkOutput("fill_credits0", get_credits(0), 0);
        repeat (2) applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fill_vld", get_vld(0), 1);
        checkOutput("fill_rdy_held", get_rdy(0), 0);
        drain(0);
        checkOutput("fill_credits_back", get_credits(0), 4);
        checkOutput("fill_err", get_err(0), 0);
        checkOutput("fill_empty", get_vld(0), 0);

        // Streaming: every word must appear exactly three cycles after issue.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1, 0, 32'h100 + k, 1);
            checkOutput("stream_rdy", get_rdy(0), 1);
            expect_word(0, 32'h100 + k, cyc + 3);
        end
        drain(0);
        checkOutput("stream_credits", get_credits(0), 4);

        // D=3 cannot cover the round trip: one blocked cycle in every four.
        for (int k = 0; k < 12; k++) begin
            bit acc;
            acc = (k % 4 != 3);
            applyStimulus(1, acc, 0, 32'h200 + k, 1);
            checkOutput("under_rdy", get_rdy(1), longint'(acc));
            if (acc) expect_word(1, 32'h200 + k, cyc + 3);
        end
        drain(1);
        checkOutput("under_err", get_err(1), 0);

        // Fill D=3 directly, then push and pop together at full.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 1, 32'h300 + k, 0);
            expect_word(1, 32'h300 + k, -1);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 1, 32'h310 + k, 1);
            checkOutput("wrap_vld", get_vld(1), 1);
            expect_word(1, 32'h310 + k, -1);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 32'h0, 1);
            checkOutput("wrap_occ", get_vld(1), 1);
        end
        applyStimulus(1, 0, 0, 32'h0, 1);
        checkOutput("wrap_empty", get_vld(1), 0);
        drain(1);
        checkOutput("wrap_err", get_err(1), 0);

        // Overflow: a push at full with no pop is dropped and flags an error.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 32'h400 + k, 0);
            expect_word(0, 32'h400 + k, -1);
        end
        repeat (3) applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("ovf_err_before", get_err(0), 0);
        applyStimulus(0, 0, 1, 32'h4FF, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("ovf_err", get_err(0), 1);
        drain(0);
        checkOutput("ovf_err_sticky", get_err(0), 1);
        checkOutput("ovf_credits", get_credits(0), 4);

        do_reset();
        checkOutput("rst2_err", get_err(0), 0);

        // Issue with no credit: error set, counter untouched.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 32'h500 + k, 0);
            expect_word(0, 32'h500 + k, -1);
        end
        repeat (3) applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("nocred_rdy", get_rdy(0), 0);
        applyStimulus(0, 1, 0, 32'h5FF, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("nocred_err", get_err(0), 1);
        checkOutput("nocred_credits", get_credits(0), 0);
        repeat (2) applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("held_credits", get_credits(0), 2);
        checkOutput("held_vld", get_vld(0), 1);

        // Reset with two words held discards them and restores all credits.
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1;
        checkOutput("midrst_vld", get_vld(0), 0);
        checkOutput("midrst_credits", get_credits(0), 4);
        checkOutput("midrst_err", get_err(0), 0);
        checkOutput("midrst_rdy", get_rdy(0), 1);
        rst = 1'b0;
        repeat (4) applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("post_rst_credits", get_credits(0), 4);
        checkOutput("final_q", q_size(0) + q_size(1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
